// File: rtl/riscv_definitions.sv
// Shared RV32I definitions: datapath widths and the writeback source
// encoding that the writeback arbiter uses as its priority state.
package riscv_definitions;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR   = 5;

    // The state names the source that wins the next contended cycle.
    // EXEC corresponds to PRI_S0 and LOAD corresponds to PRI_S1.
    typedef enum logic {
        WB_SRC_EXEC = 1'b0,
        WB_SRC_LOAD = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port.
// Source 0 is the execute pipeline and source 1 is the load unit.
// Contention is resolved round-robin. The winning write is registered
// and driven straight into register_file. The same registered write is
// exposed to decode so it can stall or forward.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = riscv_definitions::DATA_WIDTH,
    parameter int REG_ADDR   = riscv_definitions::REG_ADDR
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clk_en,
    input  logic                  i_s0_valid,
    input  logic [REG_ADDR-1:0]   i_s0_addr,
    input  logic [DATA_WIDTH-1:0] i_s0_data,
    output logic                  o_s0_ready,
    input  logic                  i_s1_valid,
    input  logic [REG_ADDR-1:0]   i_s1_addr,
    input  logic [DATA_WIDTH-1:0] i_s1_data,
    output logic                  o_s1_ready,
    output logic                  o_wr_reg_en,
    output logic [REG_ADDR-1:0]   o_write_register_addr,
    output logic [DATA_WIDTH-1:0] o_write_data,
    output logic                  o_pend_valid,
    output logic [REG_ADDR-1:0]   o_pend_addr
);

    import riscv_definitions::*;

    wb_src_e               r_priState;
    wb_src_e               w_priNext;
    logic                  w_s0Ready;
    logic                  w_s1Ready;
    logic                  r_wrEn;
    logic [REG_ADDR-1:0]   r_wrAddr;
    logic [DATA_WIDTH-1:0] r_wrData;

    // Grant decision: a lone requester always wins, and the priority state breaks ties; nothing is granted while stalled or in reset.
    always_comb begin
        w_s0Ready = 1'b0;
        w_s1Ready = 1'b0;
        w_priNext = r_priState;
        if (i_rst_n && i_clk_en) begin
            if (i_s0_valid && (!i_s1_valid || r_priState == WB_SRC_EXEC)) begin
                w_s0Ready = 1'b1;
            end else if (i_s1_valid) begin
                w_s1Ready = 1'b1;
            end
        end
        if (w_s0Ready) begin
            w_priNext = WB_SRC_LOAD;
        end else if (w_s1Ready) begin
            w_priNext = WB_SRC_EXEC;
        end
    end

    // Priority register: it advances only on enabled edges, so a stall freezes the round-robin turn.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_priState <= WB_SRC_EXEC;
        end else if (i_clk_en) begin
            r_priState <= w_priNext;
        end
    end

    // Output stage: it captures the granted write, and x0 is captured with the enable low; when idle, only the enable drops.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrEn   <= 1'b0;
            r_wrAddr <= '0;
            r_wrData <= '0;
        end else if (i_clk_en) begin
            if (w_s0Ready) begin
                r_wrEn   <= (i_s0_addr != '0);
                r_wrAddr <= i_s0_addr;
                r_wrData <= i_s0_data;
            end else if (w_s1Ready) begin
                r_wrEn   <= (i_s1_addr != '0);
                r_wrAddr <= i_s1_addr;
                r_wrData <= i_s1_data;
            end else begin
                r_wrEn   <= 1'b0;
            end
        end
    end

    assign o_s0_ready            = w_s0Ready;
    assign o_s1_ready            = w_s1Ready;
    assign o_wr_reg_en           = r_wrEn;
    assign o_write_register_addr = r_wrAddr;
    assign o_write_data          = r_wrData;
    assign o_pend_valid          = r_wrEn;
    assign o_pend_addr           = r_wrAddr;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter. A transaction-level model
// tracks whose turn it is and which write is in flight. A compare process
// checks the DUT against that model on every falling edge. Directed steps
// add literal expectations, and a register-file stand-in shows the writes
// that are actually committed.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        clkEn = 1'b1;
    logic        s0Valid = 1'b0;
    logic [4:0]  s0Addr = '0;
    logic [31:0] s0Data = '0;
    logic        s1Valid = 1'b0;
    logic [4:0]  s1Addr = '0;
    logic [31:0] s1Data = '0;
    logic        s0Ready, s1Ready, wrEn, pendValid;
    logic [4:0]  wrAddr, pendAddr;
    logic [31:0] wrData;

    int checks = 0;
    int failures = 0;

    // Model state: whose turn it is on a tie, and the write the output stage should hold.
    int          mPrio = 0;
    logic        mWrEn = 1'b0;
    logic [4:0]  mAddr = '0;
    logic [31:0] mData = '0;
    int          grantLog[$];
    logic [31:0] rfStandIn [32];

    regfile_wb_arbiter dut (
        .i_clk                 (clk),
        .i_rst_n               (rstN),
        .i_clk_en              (clkEn),
        .i_s0_valid            (s0Valid),
        .i_s0_addr             (s0Addr),
        .i_s0_data             (s0Data),
        .o_s0_ready            (s0Ready),
        .i_s1_valid            (s1Valid),
        .i_s1_addr             (s1Addr),
        .i_s1_data             (s1Data),
        .o_s1_ready            (s1Ready),
        .o_wr_reg_en           (wrEn),
        .o_write_register_addr (wrAddr),
        .o_write_data          (wrData),
        .o_pend_valid          (pendValid),
        .o_pend_addr           (pendAddr)
    );

    always #5 clk = ~clk;

    // Which source must be granted right now: -1 for none, otherwise 0 or 1.
    function automatic int expGrant();
        if (!rstN || !clkEn) return -1;
        if (s0Valid && s1Valid) return mPrio;
        if (s0Valid) return 0;
        if (s1Valid) return 1;
        return -1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic v1, input logic [4:0] a1, input logic [31:0] d1);
        s0Valid = v0; s0Addr = a0; s0Data = d0;
        s1Valid = v1; s1Addr = a1; s1Data = d1;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Transaction model: on each enabled edge the granted write is captured, and the other source gets the next turn.
    always @(posedge clk or negedge rstN) begin : modelProc
        int g;
        if (!rstN) begin
            mPrio = 0; mWrEn = 1'b0; mAddr = '0; mData = '0;
        end else if (clkEn) begin
            g = expGrant();
            if (g == 0) begin
                mWrEn = (s0Addr != 5'd0); mAddr = s0Addr; mData = s0Data; mPrio = 1;
                grantLog.push_back(0);
            end else if (g == 1) begin
                mWrEn = (s1Addr != 5'd0); mAddr = s1Addr; mData = s1Data; mPrio = 0;
                grantLog.push_back(1);
            end else begin
                mWrEn = 1'b0;
            end
        end
    end

    // Register-file stand-in: it commits whatever the write port presents on an enabled edge, and it clears on reset.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < 32; i++) rfStandIn[i] <= '0;
        end else if (clkEn && wrEn && wrAddr != 5'd0) begin
            rfStandIn[wrAddr] <= wrData;
        end
    end

    // Per-cycle comparison of every DUT output against the model, plus the upstream no-same-address guarantee.
    always @(negedge clk) begin
        int g;
        g = expGrant();
        checkOutput("s0Ready", {31'd0, s0Ready}, {31'd0, g == 0});
        checkOutput("s1Ready", {31'd0, s1Ready}, {31'd0, g == 1});
        checkOutput("wrEn", {31'd0, wrEn}, {31'd0, mWrEn});
        checkOutput("wrAddr", {27'd0, wrAddr}, {27'd0, mAddr});
        checkOutput("wrData", wrData, mData);
        checkOutput("pendValid", {31'd0, pendValid}, {31'd0, mWrEn});
        checkOutput("pendAddr", {27'd0, pendAddr}, {27'd0, mAddr});
        if (s0Valid && s1Valid && s0Addr == s1Addr && s0Addr != 5'd0) begin
            failures++;
            $display("[TB] FAIL sameAddr actual=both_valid_x%0d required=distinct", s0Addr);
        end
    end

    initial begin
        // Reset with both sources requesting
        #1 rstN = 1'b0;
        applyStimulus(1'b1, 5'd1, 32'h0000_0011, 1'b1, 5'd2, 32'h0000_0022);
        repeat (2) @(negedge clk);
        checkOutput("rstWrEn", {31'd0, wrEn}, 32'd0);
        checkOutput("rstReady", {30'd0, s0Ready, s1Ready}, 32'd0);
        checkOutput("rstData", wrData, 32'd0);
        cycle();
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("relReady", {30'd0, s0Ready, s1Ready}, 32'd2);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("relAddr", {27'd0, wrAddr}, 32'd1);
        checkOutput("relData", wrData, 32'h0000_0011);
        cycle();

        // Single source: s1 writes x5
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        checkOutput("s1Single", {31'd0, s1Ready}, 32'd1);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("singleEn", {31'd0, wrEn}, 32'd1);
        checkOutput("singleAddr", {27'd0, wrAddr}, 32'd5);
        checkOutput("singleData", wrData, 32'hDEAD_BEEF);
        checkOutput("singlePend", {26'd0, pendValid, pendAddr}, 32'h25);
        cycle();

        // Contention for six cycles: the turn starts at s0
        grantLog.delete();
        applyStimulus(1'b1, 5'd1, 32'h1111_0001, 1'b1, 5'd2, 32'h2222_0002);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("contReady", {30'd0, s0Ready, s1Ready}, (k % 2 == 0) ? 32'd2 : 32'd1);
            cycle();
        end
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        checkOutput("logLen", grantLog.size(), 32'd6);
        for (int k = 0; k < grantLog.size(); k++) checkOutput("logOrder", grantLog[k], k % 2);
        cycle();

        // An x0 write is granted, but the write enable stays low
        applyStimulus(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("x0Ready", {31'd0, s0Ready}, 32'd1);
        cycle();
        applyStimulus(1'b1, 5'd1, 32'h0000_0101, 1'b1, 5'd2, 32'h0000_0202);
        @(negedge clk);
        checkOutput("x0En", {31'd0, wrEn}, 32'd0);
        checkOutput("x0Turn", {30'd0, s0Ready, s1Ready}, 32'd1);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle();

        // Stall: grant x7, then hold the enable low for three cycles with s0 pending
        applyStimulus(1'b1, 5'd7, 32'hA5A5_A5A5, 1'b0, 5'd0, 32'd0);
        cycle();
        clkEn = 1'b0;
        applyStimulus(1'b1, 5'd8, 32'h0808_0808, 1'b0, 5'd0, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("stallHold", {25'd0, wrEn, s0Ready, s1Ready, wrAddr}, {25'd0, 1'b1, 1'b0, 1'b0, 5'd7});
            cycle();
        end
        clkEn = 1'b1;
        @(negedge clk);
        checkOutput("stallResume", {31'd0, s0Ready}, 32'd1);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("rfX7", rfStandIn[7], 32'hA5A5_A5A5);
        checkOutput("afterStallAddr", {27'd0, wrAddr}, 32'd8);
        cycle();

        // Reset in the middle of an x3 write
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h3333_3333);
        cycle();
        applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge clk);
        checkOutput("midEn", {26'd0, wrEn, wrAddr}, 32'h23);
        #2 rstN = 1'b0;
        #1;
        checkOutput("midClear", {26'd0, wrEn, wrAddr}, 32'd0);
        checkOutput("midData", wrData, 32'd0);
        checkOutput("midPend", {31'd0, pendValid}, 32'd0);
        cycle();
        rstN = 1'b1;
        cycle();
        cycle();
        @(negedge clk);
        checkOutput("rfX3", rfStandIn[3], 32'd0);
        checkOutput("postRstEn", {31'd0, wrEn}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Two-source writeback arbiter and sequencer for the RV32I register file's single write port. It shares the port between the execute pipeline (source 0: ALU/jump results) and the load unit (source 1: multi-cycle load data) using round-robin valid/ready arbitration. A registered output stage drives the register file write port and also exposes the in-flight write to decode for hazard checking. It sits between the writeback sources and `register_file`, and its outputs connect directly to that block's write port.

## Interface
- `DATA_WIDTH`, 32, write data width (from `riscv_definitions`)
- `REG_ADDR`, 5, register index width (from `riscv_definitions`)
- `i_clk`  in  1  clock
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_clk_en`  in  1  pipeline clock enable; low = global stall
- `i_s0_valid`  in  1  source 0 has a write pending
- `i_s0_addr`  in  REG_ADDR  source 0 destination register
- `i_s0_data`  in  DATA_WIDTH  source 0 write data
- `o_s0_ready`  out  1  source 0 request accepted this cycle
- `i_s1_valid`, `i_s1_addr`, `i_s1_data`, `o_s1_ready`: same as source 0, for source 1
- `o_wr_reg_en`  out  1  to `register_file` `i_wr_reg_en`
- `o_write_register_addr`  out  REG_ADDR  to `register_file` write address
- `o_write_data`  out  DATA_WIDTH  to `register_file` write data
- `o_pend_valid`  out  1  output stage holds a write not yet committed
- `o_pend_addr`  out  REG_ADDR  destination of that write; for decode stall/forward

## Operation
- A transfer happens on a source when `valid && ready` at a rising edge with `i_clk_en` = 1.
- `ready` is combinational from valid, the priority state and `i_clk_en`. It never depends on the source's own ready.
- Priority FSM, 2 states: `PRI_S0` and `PRI_S1`. Reset state is `PRI_S0`.
  - Only one source valid: it is granted, regardless of state.
  - Both valid: the source named by the state is granted; the other gets `ready` = 0.
  - After any grant, the next state gives priority to the source that was *not* granted.
  - No grant: state holds.
- At most one `ready` is high per cycle.
- `i_clk_en` = 0:
  - both readys are 0;
  - FSM and output stage hold;
  - held outputs stay asserted, so `register_file` (gated by the same enable) commits the write once the enable returns.
- Output stage, on an enabled edge:
  - With a grant: load addr and data; `o_wr_reg_en` = 1 if addr ≠ 0, else 0.
  - Without a grant: `o_wr_reg_en` ← 0; addr and data hold.
- Writes to x0 are granted and consume a priority turn, but never assert `o_wr_reg_en`.
- `o_pend_valid` = `o_wr_reg_en`; `o_pend_addr` = `o_write_register_addr`.
- Upstream guarantees that both sources are never simultaneously valid with the same nonzero addr. The bench asserts this; the RTL does not resolve it.
- Sources hold addr and data stable while valid and not ready.

## Timing
- Latency: a grant at edge N → `o_wr_reg_en` high during cycle N..N+1 → `register_file` commits at edge N+1 (when enabled).
- Throughput: one write per enabled cycle. Under contention each source gets every other slot.
- Reset (async assert): `o_wr_reg_en` = 0, addr = 0, data = 0, `o_pend_valid` = 0, FSM = `PRI_S0`, readys = 0 while `i_rst_n` = 0.
- A reset mid-operation discards the in-flight write. The write is not committed, because `register_file` resets in the same cycle.
- Release: the first enabled edge after deassertion may grant.
- Simultaneous stall and request: no transfer occurs; the request remains pending with stable data.

## Structure
- Shared package `riscv_definitions`: `DATA_WIDTH`, `REG_ADDR`, and a new `wb_src_e` enum (`WB_SRC_EXEC`, `WB_SRC_LOAD`) used for the FSM state.
- Single module, no sub-modules. The FSM is 1 flop; the output stage is plain flops.

## Test plan
- Reset: with `i_rst_n` = 0 and both sources valid, all outputs are 0 and both readys are 0. On release, s0 is granted first (`PRI_S0`).
- Single source: s1 writes x5 = 0xDEADBEEF. `o_s1_ready` = 1 the same cycle; the next cycle shows `o_wr_reg_en` = 1, addr 5, data 0xDEADBEEF, `o_pend_valid` = 1, `o_pend_addr` = 5.
- Contention: both sources continuously valid (s0 to x1, s1 to x2) for 6 cycles. Grants alternate s0, s1, s0, s1, s0, s1, with exactly one ready per cycle.
- x0 write: s0 writes x0 = 0x1234. `o_s0_ready` = 1, then `o_wr_reg_en` stays 0. The FSM moves to `PRI_S1`: with both valid next cycle, s1 is granted.
- Stall: a grant of x7 = 0xA5A5A5A5, then `i_clk_en` = 0 for 3 cycles with s0 valid. Outputs hold at `o_wr_reg_en` = 1, addr 7, and both readys stay 0. After the enable returns, the register_file read of x7 returns 0xA5A5A5A5 and s0 is granted.
- Mid-write reset: assert `i_rst_n` while `o_wr_reg_en` = 1 for x3. Outputs clear immediately and x3 reads 0 afterward.
